// File: rtl/alu_chain_pkg.sv
// Shared constants for the byte-serial ALU chain controller.
// ALU_CHAIN_EQL_EN enables the multi-byte equality opcode.
package alu_chain_pkg;

   localparam int NBYTES_MIN = 2;
   localparam int NBYTES_MAX = 4;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_NAND = 4'b0110;
   localparam logic [3:0] OP_OR   = 4'b0111;
   localparam logic [3:0] OP_EQL  = 4'b1110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic opSupported(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_NAND, OP_OR: return 1'b1;
`ifdef ALU_CHAIN_EQL_EN
         OP_EQL: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_chain_ctrl.sv
// Sequences a wide operation through an external 8-bit ALU one byte per cycle.
// Define ALU_CHAIN_EQL_EN to support the equality opcode (1110).
module alu_chain_ctrl
   import alu_chain_pkg::*;
#(
   parameter int NBYTES = 2
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                Start,
   input  logic [8*NBYTES-1:0] OpA,
   input  logic [8*NBYTES-1:0] OpB,
   input  logic [3:0]          Op,
   output logic                Busy,
   output logic                Done,
   output logic [8*NBYTES-1:0] Result,
   output logic                CarryOut,
   output logic                OpErr,
   output logic [7:0]          AluA,
   output logic [7:0]          AluB,
   output logic [3:0]          AluOp,
   output logic                AluOvIn,
   input  logic [7:0]          AluOut,
   input  logic                AluOvOut
);

   localparam int         W        = 8 * NBYTES;
   localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

   state_e         state_q, state_d;
   logic [1:0]     idx_q, idx_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [3:0]     op_q, op_d;
   logic [W-1:0]   result_q, result_d;
   logic           carry_q, carry_d;
   logic           opErr_q, opErr_d;
   logic           ovPrev_q, ovPrev_d;
`ifdef ALU_CHAIN_EQL_EN
   logic           eqlAcc_q, eqlAcc_d;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      carry_d  = carry_q;
      opErr_d  = opErr_q;
      ovPrev_d = ovPrev_q;
`ifdef ALU_CHAIN_EQL_EN
      eqlAcc_d = eqlAcc_q;
`endif
      AluA     = '0;
      AluB     = '0;
      AluOp    = '0;
      AluOvIn  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               a_d      = OpA;
               b_d      = OpB;
               op_d     = Op;
               idx_d    = '0;
               carry_d  = 1'b0;
               ovPrev_d = 1'b0;
`ifdef ALU_CHAIN_EQL_EN
               eqlAcc_d = 1'b1;
`endif
               if (opSupported(Op)) begin
                  opErr_d = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  opErr_d  = 1'b1;
                  result_d = '0;
                  state_d  = ST_DONE;
               end
            end
         end

         ST_RUN: begin
            AluA  = a_q[8*idx_q +: 8];
            AluB  = b_q[8*idx_q +: 8];
            AluOp = op_q;
            // The ALU chains add carries directly but subtract borrows, so sub inverts the link
            if (idx_q != 2'd0) begin
               if (op_q == OP_ADD)      AluOvIn = ovPrev_q;
               else if (op_q == OP_SUB) AluOvIn = ~ovPrev_q;
            end
            ovPrev_d = AluOvOut;
`ifdef ALU_CHAIN_EQL_EN
            if (op_q == OP_EQL) begin
               eqlAcc_d = eqlAcc_q & AluOut[0];
               result_d = '0;
               result_d[0] = eqlAcc_q & AluOut[0];
            end else begin
               result_d[8*idx_q +: 8] = AluOut;
            end
`else
            result_d[8*idx_q +: 8] = AluOut;
`endif
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = ST_DONE;
               if (op_q == OP_ADD)      carry_d = AluOvOut;
               else if (op_q == OP_SUB) carry_d = ~AluOvOut;
               else                     carry_d = 1'b0;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         opErr_q  <= 1'b0;
         ovPrev_q <= 1'b0;
`ifdef ALU_CHAIN_EQL_EN
         eqlAcc_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         opErr_q  <= opErr_d;
         ovPrev_q <= ovPrev_d;
`ifdef ALU_CHAIN_EQL_EN
         eqlAcc_q <= eqlAcc_d;
`endif
      end
   end

   assign Busy     = (state_q != ST_IDLE);
   assign Done     = (state_q == ST_DONE);
   assign Result   = result_q;
   assign CarryOut = carry_q;
   assign OpErr    = opErr_q;

endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Directed self-checking bench for alu_chain_ctrl driving a behavioural 8-bit ALU.
// Expectations for opcode 1110 follow ALU_CHAIN_EQL_EN.
module tb_alu_chain_ctrl;

   localparam int NBYTES = 2;
   localparam int W      = 8 * NBYTES;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          Start = 1'b0;
   logic [W-1:0]  OpA = '0;
   logic [W-1:0]  OpB = '0;
   logic [3:0]    Op = '0;
   logic          Busy, Done, CarryOut, OpErr;
   logic [W-1:0]  Result;
   logic [7:0]    AluA, AluB, AluOut;
   logic [3:0]    AluOp;
   logic          AluOvIn, AluOvOut;

   int total = 0;
   int bad   = 0;
   int lat;

   alu_chain_ctrl #(.NBYTES(NBYTES)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
      .OpA(OpA), .OpB(OpB), .Op(Op),
      .Busy(Busy), .Done(Done), .Result(Result), .CarryOut(CarryOut), .OpErr(OpErr),
      .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOvIn(AluOvIn),
      .AluOut(AluOut), .AluOvOut(AluOvOut)
   );

   always #5 Clk = ~Clk;

   // Behavioural 8-bit ALU: add/sub chain through OverflowIn, sub reports carry as not-borrow
   logic [8:0] aluSum, aluDiff;
   always_comb begin
      aluSum   = {1'b0, AluA} + {1'b0, AluB} + {8'b0, AluOvIn};
      aluDiff  = {1'b0, AluA} - {1'b0, AluB} - {8'b0, AluOvIn};
      AluOut   = 8'h00;
      AluOvOut = 1'b0;
      case (AluOp)
         4'b0000: begin AluOut = aluSum[7:0];  AluOvOut = aluSum[8];   end
         4'b0001: begin AluOut = aluDiff[7:0]; AluOvOut = ~aluDiff[8]; end
         4'b0110: AluOut = ~(AluA & AluB);
         4'b0111: AluOut = AluA | AluB;
         4'b1110: AluOut = {7'b0, (AluA == AluB)};
         default: ;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Issues one request from IDLE and returns how many edges (accept edge included) until Done
   task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [3:0] op, output int edges);
      @(negedge Clk);
      OpA = a; OpB = b; Op = op; Start = 1'b1;
      edges = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clk);
         #1;
         edges++;
         if (edges == 1) begin
            Start = 1'b0;
            OpA = ~a; OpB = ~b; Op = 4'b1111;
            if (!Done) begin
               checkOutput({tag, "_aluA0"}, 32'(AluA), 32'(a[7:0]));
               checkOutput({tag, "_aluOp"}, 32'(AluOp), 32'(op));
            end
         end
         if (Done) break;
      end
      checkOutput({tag, "_done"}, 32'(Done), 32'd1);
      checkOutput({tag, "_busy"}, 32'(Busy), 32'd1);
      checkOutput({tag, "_aluIdle"}, {AluA, AluB, AluOp, 3'b0, AluOvIn}, 32'd0);
   endtask

   task automatic finishOp(input string tag);
      @(posedge Clk);
      #1;
      checkOutput({tag, "_pulse"}, 32'(Done), 32'd0);
      checkOutput({tag, "_idle"}, 32'(Busy), 32'd0);
   endtask

   initial begin
      $display("[TB] alu_chain_ctrl directed test start");
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("rst_busy", 32'(Busy), 32'd0);
      checkOutput("rst_done", 32'(Done), 32'd0);
      checkOutput("rst_result", 32'(Result), 32'd0);
      checkOutput("rst_flags", {30'd0, CarryOut, OpErr}, 32'd0);
      checkOutput("rst_alu", {AluA, AluB, AluOp, 3'b0, AluOvIn}, 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;

      applyStimulus("add1", 16'h00FF, 16'h0001, 4'b0000, lat);
      checkOutput("add1_lat", 32'(lat), 32'd3);
      checkOutput("add1_res", 32'(Result), 32'h0100);
      checkOutput("add1_cy", 32'(CarryOut), 32'd0);
      checkOutput("add1_err", 32'(OpErr), 32'd0);
      finishOp("add1");
      checkOutput("add1_hold", 32'(Result), 32'h0100);

      applyStimulus("add2", 16'hFFFF, 16'h0001, 4'b0000, lat);
      checkOutput("add2_res", 32'(Result), 32'h0000);
      checkOutput("add2_cy", 32'(CarryOut), 32'd1);
      finishOp("add2");

      applyStimulus("sub1", 16'h0100, 16'h0001, 4'b0001, lat);
      checkOutput("sub1_res", 32'(Result), 32'h00FF);
      checkOutput("sub1_cy", 32'(CarryOut), 32'd0);
      finishOp("sub1");

      applyStimulus("sub2", 16'h0004, 16'h00BE, 4'b0001, lat);
      checkOutput("sub2_res", 32'(Result), 32'hFF46);
      checkOutput("sub2_cy", 32'(CarryOut), 32'd1);
      finishOp("sub2");

      applyStimulus("nand", 16'h0101, 16'h0101, 4'b0110, lat);
      checkOutput("nand_res", 32'(Result), 32'hFEFE);
      checkOutput("nand_cy", 32'(CarryOut), 32'd0);
      finishOp("nand");

      applyStimulus("or", 16'h1200, 16'h0034, 4'b0111, lat);
      checkOutput("or_res", 32'(Result), 32'h1234);
      finishOp("or");

`ifdef ALU_CHAIN_EQL_EN
      applyStimulus("eqlT", 16'h1234, 16'h1234, 4'b1110, lat);
      checkOutput("eqlT_lat", 32'(lat), 32'd3);
      checkOutput("eqlT_res", 32'(Result), 32'd1);
      checkOutput("eqlT_err", 32'(OpErr), 32'd0);
      finishOp("eqlT");
      applyStimulus("eqlF", 16'h1234, 16'h1235, 4'b1110, lat);
      checkOutput("eqlF_res", 32'(Result), 32'd0);
      checkOutput("eqlF_err", 32'(OpErr), 32'd0);
      finishOp("eqlF");
`else
      applyStimulus("eqlX", 16'h1234, 16'h1234, 4'b1110, lat);
      checkOutput("eqlX_lat", 32'(lat), 32'd1);
      checkOutput("eqlX_err", 32'(OpErr), 32'd1);
      checkOutput("eqlX_res", 32'(Result), 32'd0);
      finishOp("eqlX");
`endif

      applyStimulus("add3", 16'h1111, 16'h2222, 4'b0000, lat);
      checkOutput("add3_res", 32'(Result), 32'h3333);
      finishOp("add3");
      applyStimulus("bad", 16'h1234, 16'h5678, 4'b0011, lat);
      checkOutput("bad_lat", 32'(lat), 32'd1);
      checkOutput("bad_err", 32'(OpErr), 32'd1);
      checkOutput("bad_res", 32'(Result), 32'd0);
      checkOutput("bad_cy", 32'(CarryOut), 32'd0);
      finishOp("bad");

      // Start pulses during RUN and DONE must not launch a second operation
      @(negedge Clk);
      OpA = 16'h0101; OpB = 16'h0101; Op = 4'b0110; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      @(negedge Clk);
      OpA = 16'h0005; OpB = 16'h0005; Op = 4'b0000; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      checkOutput("ign_run_busy", 32'(Busy), 32'd1);
      @(posedge Clk); #1;
      checkOutput("ign_done", 32'(Done), 32'd1);
      checkOutput("ign_res", 32'(Result), 32'hFEFE);
      @(negedge Clk);
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      checkOutput("ign_dstart_busy", 32'(Busy), 32'd0);
      checkOutput("ign_dstart_res", 32'(Result), 32'hFEFE);
      @(posedge Clk); #1;
      checkOutput("ign_idle_busy", 32'(Busy), 32'd0);
      checkOutput("ign_idle_res", 32'(Result), 32'hFEFE);

      // Asynchronous reset partway through RUN discards the partial result
      @(negedge Clk);
      OpA = 16'h0203; OpB = 16'h0405; Op = 4'b0000; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      @(posedge Clk); #1;
      checkOutput("mid_busy", 32'(Busy), 32'd1);
      checkOutput("mid_partial", 32'(Result), 32'hFE08);
      #2;
      Reset_n = 1'b0;
      #1;
      checkOutput("mrst_busy", 32'(Busy), 32'd0);
      checkOutput("mrst_done", 32'(Done), 32'd0);
      checkOutput("mrst_res", 32'(Result), 32'd0);
      checkOutput("mrst_alu", {AluA, AluB, AluOp, 3'b0, AluOvIn}, 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      applyStimulus("post", 16'h0001, 16'h0001, 4'b0000, lat);
      checkOutput("post_lat", 32'(lat), 32'd3);
      checkOutput("post_res", 32'(Result), 32'h0002);
      finishOp("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
